// File: rtl/jk_seq_pkg.sv
// Shared op codes, FSM state encoding and JK drive codes for the bank sequencer.
package jk_seq_pkg;

   localparam logic [2:0] OP_NOP    = 3'd0;
   localparam logic [2:0] OP_CLEAR  = 3'd1;
   localparam logic [2:0] OP_SET    = 3'd2;
   localparam logic [2:0] OP_LOAD   = 3'd3;
   localparam logic [2:0] OP_TOGGLE = 3'd4;
   localparam logic [2:0] OP_COUNT  = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_APPLY = 3'd1,
      ST_COUNT = 3'd2,
      ST_CHECK = 3'd3,
      ST_RESP  = 3'd4
   } state_t;

   // {j,k} pairs for one flop
   localparam logic [1:0] JK_HOLD   = 2'b00;
   localparam logic [1:0] JK_RESET  = 2'b01;
   localparam logic [1:0] JK_SET    = 2'b10;
   localparam logic [1:0] JK_TOGGLE = 2'b11;

   // Per-bit {j,k} for a single-cycle APPLY of the given op
   function automatic logic [1:0] apply_code(input logic [2:0] op, input logic bit_d);
      logic [1:0] code;
      case (op)
         OP_CLEAR:  code = JK_RESET;
         OP_SET:    code = JK_SET;
         OP_LOAD:   code = bit_d ? JK_SET : JK_RESET;
         OP_TOGGLE: code = bit_d ? JK_TOGGLE : JK_HOLD;
         default:   code = JK_HOLD;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/jk_toggle_gen.sv
// Binary up-count toggle vector: bit i toggles when all lower bits are 1.
module jk_toggle_gen #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] t
);

   logic carry;

   // Ripple the all-ones carry upward; carry into bit 0 is always 1
   always_comb begin
      t     = '0;
      carry = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         t[i]  = carry;
         carry = carry & q[i];
      end
   end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Command-driven controller for a bank of JK flops: applies an op, reads the
// bank back, compares with the predicted value and returns a response.
module jk_bank_sequencer
   import jk_seq_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_q,
   output logic             rsp_err
);

   state_t           state, state_nxt;
   logic [2:0]       op_r;
   logic [WIDTH-1:0] data_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] exp_r;
   logic [WIDTH-1:0] exp_nxt;
   logic [WIDTH-1:0] tgl;
   logic             accept;
   logic             illegal;

   jk_toggle_gen #(.WIDTH(WIDTH)) u_tgl (
      .q (q),
      .t (tgl)
   );

   assign accept    = (state == ST_IDLE) && cmd_valid;
   assign illegal   = (cmd_op > OP_COUNT);
   assign busy      = (state != ST_IDLE);
   assign rsp_valid = (state == ST_RESP);

   // Predicted bank value after the incoming op, captured at accept
   always_comb begin
      exp_nxt = q;
      case (cmd_op)
         OP_CLEAR:  exp_nxt = '0;
         OP_SET:    exp_nxt = '1;
         OP_LOAD:   exp_nxt = cmd_data;
         OP_TOGGLE: exp_nxt = q ^ cmd_data;
         OP_COUNT:  exp_nxt = q + WIDTH'(cmd_count);
         default:   exp_nxt = q;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next state and bank drive; bank holds (j=k=0) outside APPLY/COUNT
   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      j         = '0;
      k         = '0;
      case (state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               if (illegal)                  state_nxt = ST_RESP;
               else if (cmd_op != OP_COUNT)  state_nxt = ST_APPLY;
               else if (cmd_count != '0)     state_nxt = ST_COUNT;
               else                          state_nxt = ST_CHECK;
            end
         end
         ST_APPLY: begin
            for (int i = 0; i < WIDTH; i++) {j[i], k[i]} = apply_code(op_r, data_r[i]);
            state_nxt = ST_CHECK;
         end
         ST_COUNT: begin
            j = tgl;
            k = tgl;
            if (cnt_r == CNT_W'(1)) state_nxt = ST_CHECK;
         end
         ST_CHECK: state_nxt = ST_RESP;
         ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Command capture and COUNT step counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_r   <= OP_NOP;
         data_r <= '0;
         cnt_r  <= '0;
         exp_r  <= '0;
      end else if (accept) begin
         op_r   <= cmd_op;
         data_r <= cmd_data;
         cnt_r  <= cmd_count;
         exp_r  <= exp_nxt;
      end else if (state == ST_COUNT) begin
         cnt_r  <= cnt_r - CNT_W'(1);
      end
   end

   // Response registers: illegal ops answer straight from IDLE, others from CHECK
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_q   <= '0;
         rsp_err <= 1'b0;
      end else if (accept && illegal) begin
         rsp_q   <= q;
         rsp_err <= 1'b1;
      end else if (state == ST_CHECK) begin
         rsp_q   <= q;
         rsp_err <= (q != exp_r);
      end
   end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench: sequencer driving a behavioural JK bank, responses checked
// against a scoreboard of bench-predicted values.
module tb_jk_bank_sequencer;

   localparam int WIDTH = 4;
   localparam int CNT_W = 8;

   typedef struct {
      logic [WIDTH-1:0] q;
      logic             err;
   } rsp_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             bank_rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [2:0]       cmd_op = '0;
   logic [WIDTH-1:0] cmd_data = '0;
   logic [CNT_W-1:0] cmd_count = '0;
   logic [WIDTH-1:0] j, k, q;
   logic             busy, rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [WIDTH-1:0] rsp_q;
   logic             rsp_err;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   rsp_t sb[$];

   jk_bank_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_count (cmd_count),
      .j         (j),
      .k         (k),
      .q         (q),
      .busy      (busy),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_q     (rsp_q),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   // Edge counter for latency measurement
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural JK bank with its own reset
   always @(posedge clk or posedge bank_rst) begin
      if (bank_rst) q <= '0;
      else begin
         for (int i = 0; i < WIDTH; i++) begin
            case ({j[i], k[i]})
               2'b01:   q[i] <= 1'b0;
               2'b10:   q[i] <= 1'b1;
               2'b11:   q[i] <= ~q[i];
               default: q[i] <= q[i];
            endcase
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a command, push its expected response, return #1 after the accept edge
   task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] d,
                        input logic [CNT_W-1:0] n, input logic [WIDTH-1:0] eq, input logic ee);
      int w;
      rsp_t e;
      e.q = eq;
      e.err = ee;
      sb.push_back(e);
      cmd_op = op; cmd_data = d; cmd_count = n; cmd_valid = 1'b1;
      w = 0;
      while (!cmd_ready && w < 50) begin @(posedge clk); #1; w++; end
      if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      acc_cyc = cyc;
   endtask

   // Wait for a response, check latency and scoreboard, optionally stall then handshake
   task automatic wait_rsp(input int exp_lat, input int hold, input bit do_hs);
      int w;
      rsp_t e;
      w = 0;
      while (!rsp_valid && w < 200) begin @(posedge clk); #1; w++; end
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      if (exp_lat > 0) chk("latency", 32'(cyc - acc_cyc + 1), 32'(exp_lat));
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'(sb.size()), 32'd1);
         e.q = 'x; e.err = 1'bx;
      end else e = sb.pop_front();
      chk("rsp_q", 32'(rsp_q), 32'(e.q));
      chk("rsp_err", 32'(rsp_err), 32'(e.err));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_q", 32'(rsp_q), 32'(e.q));
         chk("hold_err", 32'(rsp_err), 32'(e.err));
         chk("hold_ready", 32'(cmd_ready), 32'd0);
      end
      if (do_hs) begin
         rsp_ready = 1'b1;
         @(posedge clk); #1;
         rsp_ready = 1'b0;
      end
   endtask

   // Safety net against a hung run
   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_j", 32'(j), 32'd0);
      chk("rst_k", 32'(k), 32'd0);
      chk("rst_rsp_q", 32'(rsp_q), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      reset = 1'b0;
      bank_rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_ready", 32'(cmd_ready), 32'd1);

      // Reset mid-COUNT: bank counts 0->3, then reset drops the command
      issue(3'd5, 4'h0, 8'd10, 4'h0, 1'b0);
      void'(sb.pop_back());
      repeat (3) @(posedge clk);
      #1;
      chk("mid_count_q", 32'(q), 32'h3);
      chk("mid_count_busy", 32'(busy), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("async_j", 32'(j), 32'd0);
      chk("async_k", 32'(k), 32'd0);
      chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("frozen_q", 32'(q), 32'h3);
      reset = 1'b0;
      @(posedge clk); #1;

      // CLEAR then LOAD 1010
      issue(3'd1, 4'h0, 8'd0, 4'h0, 1'b0);
      wait_rsp(3, 0, 1);
      issue(3'd3, 4'b1010, 8'd0, 4'b1010, 1'b0);
      wait_rsp(3, 0, 1);

      // TOGGLE mask 0110 from 1010
      issue(3'd4, 4'b0110, 8'd0, 4'b1100, 1'b0);
      wait_rsp(3, 0, 1);

      // COUNT 5 from 1110 wraps to 0011
      issue(3'd3, 4'b1110, 8'd0, 4'b1110, 1'b0);
      wait_rsp(3, 0, 1);
      issue(3'd5, 4'h0, 8'd5, 4'b0011, 1'b0);
      wait_rsp(7, 0, 1);

      // Illegal op: immediate error response, bank untouched
      issue(3'd7, 4'hF, 8'd3, 4'b0011, 1'b1);
      chk("illegal_j", 32'(j), 32'd0);
      chk("illegal_k", 32'(k), 32'd0);
      wait_rsp(1, 0, 1);
      chk("illegal_bank", 32'(q), 32'b0011);

      // COUNT 0 is a pure readback
      issue(3'd5, 4'h0, 8'd0, 4'b0011, 1'b0);
      wait_rsp(2, 0, 1);

      // SET with a 4-cycle response stall, then back-to-back LOAD 0101
      issue(3'd2, 4'h0, 8'd0, 4'b1111, 1'b0);
      wait_rsp(3, 4, 1'b0);
      begin
         rsp_t e;
         e.q = 4'b0101;
         e.err = 1'b0;
         sb.push_back(e);
      end
      cmd_op = 3'd3; cmd_data = 4'b0101; cmd_count = '0; cmd_valid = 1'b1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("hs_edge_idle", 32'(busy), 32'd0);
      chk("hs_edge_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      chk("b2b_accepted", 32'(busy), 32'd1);
      cmd_valid = 1'b0;
      acc_cyc = cyc;
      wait_rsp(3, 0, 1);

      // NOP reads back unchanged value
      issue(3'd0, 4'hA, 8'd0, 4'b0101, 1'b0);
      wait_rsp(3, 0, 1);

      // External bank reset during COUNT 8 from 0101: 5->6->7, reset to 0, then 6 more steps
      issue(3'd5, 4'h0, 8'd8, 4'b0110, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #1 bank_rst = 1'b1;
      #1 bank_rst = 1'b0;
      wait_rsp(10, 0, 1);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
